// File: rtl/colsr_pkg.sv
// Shared helpers for the column shift loader: column geometry functions and FSM state type.
// Geometry is a pure function of the multiplier width n.
package colsr_pkg;

  typedef enum logic {FILL, FULL} state_t;

  function automatic int col_count(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int total_bits(input int n);
    return n * n;
  endfunction

  // Partial-product column heights rise 1..n then fall back to 1.
  function automatic int col_height(input int n, input int i);
    return ((i + 1) < (2 * n - 1 - i)) ? (i + 1) : (2 * n - 1 - i);
  endfunction

  function automatic int col_offset(input int n, input int i);
    int off;
    off = 0;
    for (int j = 0; j < i; j++) off += col_height(n, j);
    return off;
  endfunction

endpackage

// File: rtl/colsr_column.sv
// Single partial-product column: H-bit shift register, newest bit at LSB, sync clear.
// Latency 1 cycle; no backpressure (shift_en is the only qualifier, clear wins).
module colsr_column #(
  parameter int H = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         din,
  output logic [H-1:0] col
);

  generate
    if (H == 1) begin : g_load
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        col <= '0;
        else if (clear)    col <= '0;
        else if (shift_en) col <= din;
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        col <= '0;
        else if (clear)    col <= '0;
        else if (shift_en) col <= {col[H-2:0], din};
      end
    end
  endgenerate

endmodule

// File: rtl/column_shift_loader.sv
// Serial-to-column loader: N accepted beats fill 2N-1 columns, presented as one frame.
// Latency: out_valid rises the cycle after the N-th beat; in_ready low while a frame waits for out_ready.
// Optional COLSR_PARITY_EN adds a registered frame_parity output.
module column_shift_loader
  import colsr_pkg::*;
#(
  parameter  int N     = 13,
  localparam int COLS  = col_count(N),
  localparam int TOTAL = total_bits(N),
  localparam int CW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COLS-1:0]  src_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TOTAL-1:0] cols_flat,
  output logic [CW-1:0]    beat_cnt
`ifdef COLSR_PARITY_EN
  ,
  output logic             frame_parity
`endif
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] beat_q;
  logic          shift_en;

  assign shift_en  = in_valid && (state_q == FILL);
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign beat_cnt  = beat_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: if (in_valid && (beat_q == LAST_BEAT)) state_d = FULL;
        FULL: if (out_ready) state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clear)                                beat_q <= '0;
      else if (shift_en)                        beat_q <= beat_q + CW'(1);
      else if ((state_q == FULL) && out_ready)  beat_q <= '0;
    end
  end

`ifdef COLSR_PARITY_EN
  logic [COLS-1:0] col_msb;
  logic            parity_q;
`endif

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    localparam int H   = col_height(N, gi);
    localparam int OFF = col_offset(N, gi);

    colsr_column #(.H(H)) u_col (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .shift_en (shift_en),
      .din      (src_bits[gi]),
      .col      (cols_flat[OFF+H-1:OFF])
    );

`ifdef COLSR_PARITY_EN
    assign col_msb[gi] = cols_flat[OFF+H-1];
`endif
  end

`ifdef COLSR_PARITY_EN
  // Each shift drops a column's MSB and adds its new LSB, so parity updates incrementally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        parity_q <= 1'b0;
    else if (clear)    parity_q <= 1'b0;
    else if (shift_en) parity_q <= parity_q ^ (^src_bits) ^ (^col_msb);
  end

  assign frame_parity = parity_q;
`endif

endmodule

// File: doc/column_shift_loader.md
Name: column_shift_loader

Overview:
- Parametrised, handshaked serial-to-column loader for the compressor test harness. Replaces the fixed-size free-running loader used for one multiplier width.
- For an N-bit multiplier it holds 2N-1 partial-product columns with heights 1,2,..,N,..,2,1.
- Each column shifts in one bit per accepted beat. After N beats the full column set is presented to the compressor as one frame under a valid/ready handshake.

Parameters:
- N, 13, multiplier operand width; gives COLS=2N-1 columns and TOTAL=N*N bits.
- H(i) (derived, not overridable): column height min(i+1, 2N-1-i) for i in 0..COLS-1.
- OFF(i) (derived): flat bit offset of column i, equal to sum of H(j) for j<i.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous frame abort
- in_valid  in  1  src_bits beat valid
- in_ready  out  1  loader accepts a beat
- src_bits  in  COLS  one serial bit per column; bit i feeds column i
- out_valid  out  1  complete frame held on cols_flat
- out_ready  in  1  downstream consumes the frame
- cols_flat  out  TOTAL  column i occupies [OFF(i)+H(i)-1 : OFF(i)]; newest bit at LSB of the column
- beat_cnt  out  $clog2(N+1)  accepted beats in the current frame

Behaviour:
- Reset (rst_n=0, asynchronous): all column registers 0, beat_cnt=0, state FILL, out_valid=0, in_ready=1 once reset is released.
- FSM with two states, FILL and FULL.
- FILL:
  - in_ready=1, out_valid=0.
  - An accepted beat is in_valid&&in_ready. On each accepted beat every column i performs col_i <= {col_i[H(i)-2:0], src_bits[i]}; a height-1 column is a plain load.
  - Each accepted beat increments beat_cnt.
  - When the N-th beat is accepted: beat_cnt=N and next state is FULL.
  - Cycles with in_valid=0 hold all state.
- FULL:
  - in_ready=0, out_valid=1; cols_flat and beat_cnt are stable.
  - in_valid is ignored.
  - out_ready=1: next cycle state=FILL, beat_cnt=0. Column registers are retained; the next frame's N beats overwrite them completely.
- Column contents: column i holds the last H(i) accepted bits of lane i. Bit 0 is the most recent beat; bit H(i)-1 is beat N-H(i)+1.
- Latency: out_valid rises the cycle after the N-th accepted beat. There is no same-cycle bypass; a new frame's first beat is accepted no earlier than one cycle after out_ready.
- clear=1 (synchronous): next cycle columns=0, beat_cnt=0, state=FILL. clear has priority over in_valid and out_ready in the same cycle.
- Reset mid-frame: the partial frame is discarded, with no output.
- Outputs are driven directly from registers; there is no combinational path from in_valid/out_ready to cols_flat.
- in_ready depends only on state, never on in_valid.

Optional Feature:
- Macro COLSR_PARITY_EN.
- Defined:
  - Adds output frame_parity (1 bit), the XOR of all TOTAL bits of cols_flat.
  - It is registered and updated in the same cycle the columns update, so it is valid whenever out_valid=1.
  - Reset and clear set it to 0.
- Undefined: the port and its logic are absent. Everything else is identical.

Decomposition:
- Shared package colsr_pkg holds:
  - constant functions col_height(n,i) and col_offset(n,i);
  - localparam helpers for COLS and TOTAL;
  - the state enum typedef {FILL, FULL}.
- One sub-module, colsr_column: a single parametrised shift register with width H, shift enable and synchronous clear. It is instantiated COLS times by a generate loop.
- The FSM and beat counter stay in the top module.

Test Plan:
- N=3, reset then three beats src_bits=5'b11111, 5'b00000, 5'b10101, out_ready=0 -> out_valid=1 one cycle after beat 3; cols_flat=9'h129; beat_cnt=3; frame_parity=0 (if enabled).
- N=3, FULL held 5 cycles with in_valid=1, src_bits toggling -> cols_flat unchanged and in_ready=0; then out_ready=1 for one cycle -> next cycle out_valid=0, beat_cnt=0, in_ready=1.
- N=13, 13 beats of all-ones with in_valid gaps of 0-3 cycles -> cols_flat=169 ones, out_valid rises only after beat 13, beat_cnt=13.
- N=3, two beats then clear=1 together with in_valid=1 -> next cycle beat_cnt=0, columns 0, the beat is not counted; 3 further beats produce a correct frame.
- N=3, rst_n pulsed low mid-cycle after 2 beats -> beat_cnt, cols_flat and out_valid go to 0 immediately without waiting for clk.
- N=1 -> COLS=1, each accepted beat fills the frame; alternating in_valid/out_ready achieves one frame per 2 cycles.
